// File: rtl/updown_counter_param.sv
// updown_counter_param
//    Parametrised modulo-(MAX+1) up/down counter with count enable, synchronous
//    load (clamped to MAX), wrap/saturate mode select, combinational terminal
//    count, a registered one-cycle wrap pulse and a sticky saturation flag.
//
// Parameters
//    WIDTH      counter width in bits (>= 1)
//    MAX        highest count value, 0 < MAX <= 2^WIDTH-1
//
// Ports
//    Clk        clock, rising edge
//    rst        asynchronous active-low reset
//    en         count enable (0 = hold)
//    UpOrDown   1 = up, 0 = down
//    sat        1 = saturate at the bounds, 0 = wrap
//    load       synchronous load strobe (priority over en)
//    load_val   value to load, clamped to MAX
//    match_val  compare value (only with UPDOWN_COUNTER_MATCH_EN)
//    Count      current count (registered)
//    tc         terminal count (combinational, for same-cycle cascading)
//    wrap_pulse one-cycle registered pulse per wrap event
//    sat_hit    sticky: a saturating step was blocked; cleared by load/reset
//    match      registered Count == match_val (only with UPDOWN_COUNTER_MATCH_EN)
//
// Optional feature macro: UPDOWN_COUNTER_MATCH_EN
module updown_counter_param #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = 15
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             en,
   input  logic             UpOrDown,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNTER_MATCH_EN
   input  logic [WIDTH-1:0] match_val,
   output logic             match,
`endif
   output logic [WIDTH-1:0] Count,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             sat_hit
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_hit_q, sat_hit_d;

   // Bounds are tested explicitly rather than relying on 2^WIDTH rollover,
   // since MAX may be below the natural range of the register.
   always_comb begin
      count_d   = count_q;
      wrap_d    = 1'b0;
      sat_hit_d = sat_hit_q;
      if (load) begin
         count_d   = (load_val > MaxVal) ? MaxVal : load_val;
         sat_hit_d = 1'b0;
      end else if (en) begin
         if (UpOrDown) begin
            if (count_q < MaxVal) begin
               count_d = count_q + One;
            end else if (!sat) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               sat_hit_d = 1'b1;
            end
         end else begin
            if (count_q > '0) begin
               count_d = count_q - One;
            end else if (!sat) begin
               count_d = MaxVal;
               wrap_d  = 1'b1;
            end else begin
               sat_hit_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         wrap_q    <= 1'b0;
         sat_hit_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrap_q    <= wrap_d;
         sat_hit_q <= sat_hit_d;
      end
   end

   assign Count      = count_q;
   assign wrap_pulse = wrap_q;
   assign sat_hit    = sat_hit_q;
   assign tc         = en & ((UpOrDown & (count_q == MaxVal)) | (~UpOrDown & (count_q == '0)));

`ifdef UPDOWN_COUNTER_MATCH_EN
   // Compared against the next count so match lines up with Count itself.
   logic match_q;

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         match_q <= 1'b0;
      end else begin
         match_q <= (count_d == match_val);
      end
   end

   assign match = match_q;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: table-driven vectors, hand-written corner
// sequences, randomized stimulus against an arithmetic reference model, and a
// two-digit BCD cascade. Instance 0 uses MAX=9, instance 1 MAX=15.
module tb_updown_counter_param;

   logic       Clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, UpOrDown = 1'b0, sat = 1'b0, load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] match_val = 4'd3;

   logic [1:0][3:0] cnt_v;
   logic [1:0]      tc_v, wp_v, sh_v, mt_v;

   // Cascade pair
   logic       cas_en = 1'b0;
   logic [3:0] u_cnt, t_cnt;
   logic       u_tc, t_tc, u_wp, t_wp, u_sh, t_sh, u_mt, t_mt;

   always #5 Clk = ~Clk;

   updown_counter_param #(.WIDTH(4), .MAX(9)) u_dut9 (
      .Clk(Clk), .rst(rst), .en(en), .UpOrDown(UpOrDown), .sat(sat), .load(load),
      .load_val(load_val),
`ifdef UPDOWN_COUNTER_MATCH_EN
      .match_val(match_val), .match(mt_v[0]),
`endif
      .Count(cnt_v[0]), .tc(tc_v[0]), .wrap_pulse(wp_v[0]), .sat_hit(sh_v[0])
   );

   updown_counter_param #(.WIDTH(4), .MAX(15)) u_dut15 (
      .Clk(Clk), .rst(rst), .en(en), .UpOrDown(UpOrDown), .sat(sat), .load(load),
      .load_val(load_val),
`ifdef UPDOWN_COUNTER_MATCH_EN
      .match_val(match_val), .match(mt_v[1]),
`endif
      .Count(cnt_v[1]), .tc(tc_v[1]), .wrap_pulse(wp_v[1]), .sat_hit(sh_v[1])
   );

   updown_counter_param #(.WIDTH(4), .MAX(9)) u_units (
      .Clk(Clk), .rst(rst), .en(cas_en), .UpOrDown(1'b1), .sat(1'b0), .load(1'b0),
      .load_val(4'd0),
`ifdef UPDOWN_COUNTER_MATCH_EN
      .match_val(match_val), .match(u_mt),
`endif
      .Count(u_cnt), .tc(u_tc), .wrap_pulse(u_wp), .sat_hit(u_sh)
   );

   updown_counter_param #(.WIDTH(4), .MAX(9)) u_tens (
      .Clk(Clk), .rst(rst), .en(u_tc), .UpOrDown(1'b1), .sat(1'b0), .load(1'b0),
      .load_val(4'd0),
`ifdef UPDOWN_COUNTER_MATCH_EN
      .match_val(match_val), .match(t_mt),
`endif
      .Count(t_cnt), .tc(t_tc), .wrap_pulse(t_wp), .sat_hit(t_sh)
   );

`ifndef UPDOWN_COUNTER_MATCH_EN
   assign mt_v = '0;
   assign u_mt = 1'b0;
   assign t_mt = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state per instance
   int m_cnt[2];
   int m_wp[2];
   int m_sh[2];
   int m_mt[2];
   int maxv[2] = '{9, 15};
   logic last_tc0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_wp[i] = 0; m_sh[i] = 0; m_mt[i] = 0;
      end
   endtask

   // Behaviour expressed as integer arithmetic on the count range [0, MAX].
   task automatic model_edge(input logic l, input int lv, input logic e, input logic u,
                             input logic s);
      for (int i = 0; i < 2; i++) begin
         int nxt;
         m_wp[i] = 0;
         if (l) begin
            m_cnt[i] = (lv > maxv[i]) ? maxv[i] : lv;
            m_sh[i]  = 0;
         end else if (e) begin
            nxt = m_cnt[i] + (u ? 1 : -1);
            if (nxt < 0 || nxt > maxv[i]) begin
               if (s) m_sh[i] = 1;
               else begin
                  m_cnt[i] = (nxt + maxv[i] + 1) % (maxv[i] + 1);
                  m_wp[i]  = 1;
               end
            end else begin
               m_cnt[i] = nxt;
            end
         end
         m_mt[i] = (m_cnt[i] == int'(match_val)) ? 1 : 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s count[%0d]", tag, i), 32'(cnt_v[i]), 32'(m_cnt[i]));
         chk($sformatf("%s wrap[%0d]", tag, i), 32'(wp_v[i]), 32'(m_wp[i]));
         chk($sformatf("%s sat_hit[%0d]", tag, i), 32'(sh_v[i]), 32'(m_sh[i]));
`ifdef UPDOWN_COUNTER_MATCH_EN
         chk($sformatf("%s match[%0d]", tag, i), 32'(mt_v[i]), 32'(m_mt[i]));
`endif
      end
   endtask

   // Entered and left at posedge+1.
   task automatic step(input logic l, input logic [3:0] lv, input logic e, input logic u,
                       input logic s);
      load = l; load_val = lv; en = e; UpOrDown = u; sat = s;
      #1;
      for (int i = 0; i < 2; i++) begin
         int etc;
         etc = (e && ((u && m_cnt[i] == maxv[i]) || (!u && m_cnt[i] == 0))) ? 1 : 0;
         chk($sformatf("tc[%0d]", i), 32'(tc_v[i]), 32'(etc));
      end
      last_tc0 = tc_v[0];
      @(posedge Clk);
      model_edge(l, int'(lv), e, u, s);
      #1;
      check_all("step");
   endtask

   // Reset pulse between clock edges; outputs must clear before any edge.
   task automatic async_reset();
      en = 1'b0; load = 1'b0;
      @(negedge Clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("async rst");
      @(posedge Clk);
      #1 check_all("rst held");
      @(negedge Clk);
      rst = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   typedef struct {
      logic       l;
      logic [3:0] lv;
      logic       e, u, s;
      logic [3:0] exp_cnt;
      logic       exp_wp, exp_sh, exp_tc;
   } vec_t;

   vec_t vecs[17];

   initial begin
      int tens_pulses, units_pulses;

      vecs[0]  = '{1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0};

      // Power-on reset
      model_reset();
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check_all("reset");
      rst = 1'b1;
      @(posedge Clk);
      #1;

      // Table vectors (instance 0, MAX=9)
      for (int k = 0; k < 17; k++) begin
         step(vecs[k].l, vecs[k].lv, vecs[k].e, vecs[k].u, vecs[k].s);
         chk($sformatf("vec%0d count", k), 32'(cnt_v[0]), 32'(vecs[k].exp_cnt));
         chk($sformatf("vec%0d wrap", k), 32'(wp_v[0]), 32'(vecs[k].exp_wp));
         chk($sformatf("vec%0d sat_hit", k), 32'(sh_v[0]), 32'(vecs[k].exp_sh));
         chk($sformatf("vec%0d tc", k), 32'(last_tc0), 32'(vecs[k].exp_tc));
      end

      // Hold: en = 0 for five edges
      step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 4'd0, 1'b0, k[0], 1'b1);
         chk("hold count", 32'(cnt_v[0]), 32'd5);
      end

      // BCD up from 0: 1..9, 0 with one wrap pulse after 9->0
      step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
         chk("bcd count", 32'(cnt_v[0]), 32'(k % 10));
         chk("bcd wrap", 32'(wp_v[0]), (k == 10) ? 32'd1 : 32'd0);
      end
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk("bcd wrap clears", 32'(wp_v[0]), 32'd0);

      // Saturate down at 0 for three edges
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
         chk("sat count", 32'(cnt_v[0]), 32'd0);
         chk("sat wrap", 32'(wp_v[0]), 32'd0);
         chk("sat flag", 32'(sh_v[0]), 32'd1);
      end

      // Async reset mid-count: set sat_hit, count to 7, pulse rst
      async_reset();
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk("pre-rst count15", 32'(cnt_v[1]), 32'd7);
      async_reset();
      chk("post-rst count15", 32'(cnt_v[1]), 32'd0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk("first up after rst", 32'(cnt_v[1]), 32'd1);

      // Randomized against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         step(($urandom_range(0, 9) == 0), 4'($urandom), ($urandom_range(0, 9) < 7),
              1'($urandom), 1'($urandom));
      end

      // Cascade: two BCD digits, tens enabled by units tc
      async_reset();
      tens_pulses  = 0;
      units_pulses = 0;
      cas_en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge Clk);
         #1;
         chk("cascade units", 32'(u_cnt), 32'((k % 100) % 10));
         chk("cascade tens", 32'(t_cnt), 32'((k % 100) / 10));
         if (u_wp) units_pulses++;
         if (t_wp) tens_pulses++;
      end
      cas_en = 1'b0;
      chk("cascade units pulses", 32'(units_pulses), 32'd10);
      chk("cascade tens pulses", 32'(tens_pulses), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
